// File: rtl/led_shift_driver.sv
// led_shift_driver: serialises an active-low LED vector into a 74HC595-style
// shift-register chain, MSB first, followed by a storage-latch pulse.
// A frame goes out when the vector changes, or when the idle refresh timer
// expires. Changes seen while a frame is in flight are remembered and
// trigger a follow-up frame.
module led_shift_driver #(
    parameter int N_LEDS  = 16,
    parameter int CLK_DIV = 8,
    parameter int REFRESH = 125000,
    parameter int INVERT  = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [N_LEDS-1:0] led_in,
    output logic              sr_clk,
    output logic              sr_data,
    output logic              sr_latch,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(N_LEDS + 1);
    localparam int TMR_W = $clog2(REFRESH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_LEDS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH - 1);
    localparam logic             INV      = (INVERT != 0);

    state_t             state;
    state_t             state_d;

    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_d;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_d;
    logic [N_LEDS-1:0]  shreg;
    logic [N_LEDS-1:0]  shreg_d;
    logic [N_LEDS-1:0]  last_sent;
    logic [N_LEDS-1:0]  last_d;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_d;
    logic               pending;
    logic               pending_d;

    logic               sr_clk_d;
    logic               sr_data_d;
    logic               sr_latch_d;
    logic               busy_d;

    logic               div_done;
    logic               bit_last;
    logic               changed;
    logic               refresh_due;

    assign div_done    = (div_cnt == DIV_LAST);
    assign bit_last    = (bit_cnt == BIT_LAST);
    assign changed     = (led_in != last_sent);
    assign refresh_due = (timer == TMR_LAST);

    // State register plus the registered serial outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sr_clk   <= 1'b0;
            sr_data  <= 1'b0;
            sr_latch <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            sr_clk   <= sr_clk_d;
            sr_data  <= sr_data_d;
            sr_latch <= sr_latch_d;
            busy     <= busy_d;
        end
    end

    // Next-state decode: frame trigger, half-period pacing, bit count.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (changed || refresh_due || pending) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_done) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (div_done) begin
                    state_d = bit_last ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                if (div_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every pin is a flop output.
    // sr_data uses the next shift-register value, so the bit captured on
    // entry to SHIFT_LO is already the post-load / post-shift MSB.
    always_comb begin
        sr_clk_d   = (state_d == SHIFT_HI);
        sr_latch_d = (state_d == LATCH);
        busy_d     = (state_d != IDLE);
        case (state_d)
            SHIFT_LO: sr_data_d = shreg_d[N_LEDS-1] ^ INV;
            SHIFT_HI: sr_data_d = sr_data;
            default:  sr_data_d = 1'b0;
        endcase
    end

    // Datapath next values: snapshot, shifting, counters, refresh, pending.
    always_comb begin
        shreg_d   = shreg;
        last_d    = last_sent;
        timer_d   = timer;
        pending_d = pending;
        bit_d     = bit_cnt;
        div_d     = '0;
        case (state)
            IDLE: begin
                timer_d = refresh_due ? '0 : timer + TMR_W'(1);
                bit_d   = '0;
            end
            LOAD: begin
                shreg_d   = led_in;
                last_d    = led_in;
                timer_d   = '0;
                pending_d = 1'b0;
                bit_d     = '0;
            end
            SHIFT_LO: begin
                div_d = div_done ? '0 : div_cnt + DIV_W'(1);
                if (changed) begin
                    pending_d = 1'b1;
                end
            end
            SHIFT_HI: begin
                div_d = div_done ? '0 : div_cnt + DIV_W'(1);
                if (changed) begin
                    pending_d = 1'b1;
                end
                if (div_done) begin
                    shreg_d = {shreg[N_LEDS-2:0], 1'b0};
                    bit_d   = bit_cnt + BIT_W'(1);
                end
            end
            LATCH: begin
                div_d = div_done ? '0 : div_cnt + DIV_W'(1);
                if (changed) begin
                    pending_d = 1'b1;
                end
                if (div_done) begin
                    bit_d = '0;
                end
            end
            default: begin
                div_d = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            last_sent <= '1;
            timer     <= '0;
            pending   <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
        end else begin
            shreg     <= shreg_d;
            last_sent <= last_d;
            timer     <= timer_d;
            pending   <= pending_d;
            bit_cnt   <= bit_d;
            div_cnt   <= div_d;
        end
    end

endmodule

// File: tb/tb_led_shift_driver.sv
// tb_led_shift_driver: scoreboard bench for led_shift_driver. A frame-level
// reference model predicts frame starts and contents; monitors reassemble the
// serial stream of a normal and an inverted instance and compare.
module tb_led_shift_driver;

    localparam int N = 8;
    localparam int D = 2;
    localparam int R = 1000;
    localparam int F = 1 + 2 * N * D + D;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] led_in = '1;

    logic sr_clk   [2];
    logic sr_data  [2];
    logic sr_latch [2];
    logic busy     [2];

    int checks = 0;
    int errors = 0;

    // Reference model state: position within a frame (-1 = idle, 0 = load).
    int           m_pos = -1;
    int           m_timer = 0;
    logic         m_pending = 1'b0;
    logic [N-1:0] m_last = '1;
    logic [N-1:0] q0 [$];
    logic [N-1:0] q1 [$];

    // Monitor state per instance.
    logic [N-1:0] mon_word [2];
    int           mon_bits [2];
    int           mon_lw   [2];
    logic         prev_clk [2];
    logic         prev_lat [2];
    logic [N-1:0] mon_exp;
    logic         mon_missing;

    led_shift_driver #(.N_LEDS(N), .CLK_DIV(D), .REFRESH(R), .INVERT(0)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .led_in  (led_in),
        .sr_clk  (sr_clk[0]),
        .sr_data (sr_data[0]),
        .sr_latch(sr_latch[0]),
        .busy    (busy[0])
    );

    led_shift_driver #(.N_LEDS(N), .CLK_DIV(D), .REFRESH(R), .INVERT(1)) u_dut_inv (
        .clock   (clock),
        .reset_n (reset_n),
        .led_in  (led_in),
        .sr_clk  (sr_clk[1]),
        .sr_data (sr_data[1]),
        .sr_latch(sr_latch[1]),
        .busy    (busy[1])
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per clock cycle, evaluated mid-cycle.
    always @(negedge clock) begin
        if (!reset_n) begin
            check("reset_outputs",
                  {24'd0, sr_clk[0], sr_data[0], sr_latch[0], busy[0],
                   sr_clk[1], sr_data[1], sr_latch[1], busy[1]}, 32'd0);
            if (m_pos >= 1) begin
                if (q0.size() > 0) void'(q0.pop_back());
                if (q1.size() > 0) void'(q1.pop_back());
            end
            m_pos     = -1;
            m_timer   = 0;
            m_pending = 1'b0;
            m_last    = '1;
        end else begin
            check("busy", {31'd0, busy[0]}, {31'd0, m_pos >= 0});
            check("busy_inv", {31'd0, busy[1]}, {31'd0, m_pos >= 0});
            if (m_pos < 0) begin
                if (led_in != m_last || m_timer == R - 1 || m_pending) m_pos = 0;
                else m_timer++;
            end else if (m_pos == 0) begin
                m_last    = led_in;
                m_timer   = 0;
                m_pending = 1'b0;
                q0.push_back(led_in);
                q1.push_back(~led_in);
                m_pos = 1;
            end else begin
                if (led_in != m_last) m_pending = 1'b1;
                m_pos++;
                if (m_pos == F) m_pos = -1;
            end
        end
    end

    // Monitors: sample data on sr_clk rising, close a frame when latch falls.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                mon_word[i] = '0;
                mon_bits[i] = 0;
                mon_lw[i]   = 0;
                prev_clk[i] = 1'b0;
                prev_lat[i] = 1'b0;
            end else begin
                if (sr_clk[i] && !prev_clk[i]) begin
                    mon_word[i] = {mon_word[i][N-2:0], sr_data[i]};
                    mon_bits[i]++;
                end
                if (sr_latch[i]) begin
                    mon_lw[i]++;
                    check("latch_data", {31'd0, sr_data[i]}, 32'd0);
                    check("latch_clk", {31'd0, sr_clk[i]}, 32'd0);
                end
                if (!busy[i]) begin
                    check("idle_data", {31'd0, sr_data[i]}, 32'd0);
                end
                if (prev_lat[i] && !sr_latch[i]) begin
                    mon_missing = 1'b0;
                    mon_exp     = '0;
                    if (i == 0) begin
                        if (q0.size() > 0) mon_exp = q0.pop_front();
                        else mon_missing = 1'b1;
                    end else begin
                        if (q1.size() > 0) mon_exp = q1.pop_front();
                        else mon_missing = 1'b1;
                    end
                    check("frame_expected", {31'd0, mon_missing}, 32'd0);
                    check("frame_data", {24'd0, mon_word[i]}, {24'd0, mon_exp});
                    check("bit_count", mon_bits[i], N);
                    check("latch_width", mon_lw[i], D);
                    mon_word[i] = '0;
                    mon_bits[i] = 0;
                    mon_lw[i]   = 0;
                end
                prev_clk[i] = sr_clk[i];
                prev_lat[i] = sr_latch[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Edges until the next frame start (busy rising); -1 on timeout.
    task automatic next_start(output int n, input int limit);
        logic prev;
        prev = busy[0];
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            tick(1);
            if (busy[0] && !prev) begin
                n = k;
                break;
            end
            prev = busy[0];
        end
    endtask

    task automatic wait_pos(input int lo, input int hi, input int limit, input string name);
        int k;
        k = 0;
        while (!(m_pos >= lo && m_pos <= hi) && k < limit) begin
            tick(1);
            k++;
        end
        if (!(m_pos >= lo && m_pos <= hi)) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (busy[0] && k < limit) begin
            tick(1);
            k++;
        end
        check("wait_idle", {31'd0, busy[0]}, 32'd0);
    endtask

    initial begin
        int n;
        int r;

        led_in  = 8'hFF;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;

        // Refresh timing from reset with an unchanged (all-off) vector.
        next_start(n, 1100);
        check("refresh_start", n, 1000);
        n = 1;
        while (busy[0] && n < 100) begin
            tick(1);
            if (busy[0]) n++;
        end
        check("busy_len", n, F);

        // A change while idle loads on the next cycle; timer restarts.
        tick(20);
        led_in = 8'hA5;
        tick(1);
        check("load_latency", {31'd0, busy[0]}, 32'd1);
        next_start(n, 1200);
        check("refresh_after_change", n, F + R);

        // Change during bit 3: frame completes unchanged, follow-up frame.
        wait_pos(13, 13, 100, "reach_bit3");
        led_in = 8'h3C;
        wait_idle(100);
        tick(1);
        check("pending_load", {31'd0, busy[0]}, 32'd1);

        // Periodic refresh with a constant vector.
        for (int k = 0; k < 3; k++) begin
            next_start(n, 1200);
            check("refresh_period", n, F + R);
        end

        // Reset during SHIFT_HI of bit 5 aborts the frame.
        led_in = 8'h5A;
        wait_pos(23, 23, 100, "reach_bit5_hi");
        check("pre_reset_clk", {31'd0, sr_clk[0]}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset",
              {24'd0, sr_clk[0], sr_data[0], sr_latch[0], busy[0],
               sr_clk[1], sr_data[1], sr_latch[1], busy[1]}, 32'd0);
        tick(3);
        reset_n = 1'b1;
        next_start(n, 50);
        check("resend_after_reset", n, 1);
        wait_idle(100);

        // Pattern for the inverted instance.
        tick(5);
        led_in = 8'h0F;
        tick(1);
        wait_idle(100);

        // Randomized changes and occasional mid-frame resets.
        for (int it = 0; it < 40; it++) begin
            tick($urandom_range(0, 80));
            r = $urandom_range(0, 9);
            if (r < 7) begin
                led_in = 8'($urandom);
            end else if (r == 7) begin
                wait_pos(1, 4 * N, 1200, "reach_shift");
                reset_n = 1'b0;
                tick($urandom_range(1, 3));
                reset_n = 1'b1;
            end
        end

        // Drain outstanding frames.
        n = 0;
        while ((m_pos != -1 || q0.size() != 0 || q1.size() != 0) && n < 300) begin
            tick(1);
            n++;
        end
        check("drain", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
